// File: rtl/yapp_rx_checker.sv
// YAPP receive port: parses framing and parity, buffers bytes in a FWFT FIFO.
// Optional packet statistics when YAPP_RX_STATS_EN is defined.
`timescale 1ns/1ps
module yapp_rx_checker #(
    parameter int DEPTH       = 16,
    parameter int SUSP_THRESH = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_data_vld,
    output logic       in_suspend,
    output logic       error,
    output logic [7:0] out_data,
    output logic       out_sop,
    output logic       out_eop,
    output logic       out_vld,
    input  logic       out_ready,
    output logic [1:0] dbg_state
`ifdef YAPP_RX_STATS_EN
    ,
    output logic [15:0] good_pkt_cnt,
    output logic [15:0] bad_pkt_cnt
`endif
);
    // Output stream: a byte transfers on any rising edge where out_vld & out_ready;
    // out_vld never drops and out_data/sop/eop never change until that transfer.
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PAYLOAD = 2'd1,
        S_PARITY  = 2'd2
    } state_t;

    state_t        r_state;
    logic [5:0]    r_len;
    logic [5:0]    r_cnt;
    logic [7:0]    r_acc;
    logic          r_error;
    logic          r_suspend;
    logic [9:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic          w_empty;
    logic          w_full;
    logic          w_rd;
    logic          w_wr;
    logic          w_ovf;
    logic          w_sop;
    logic          w_eop;
    logic          w_hdr_bad;
    logic          w_par_bad;
    logic          w_err_now;
    logic [CW-1:0] w_count_nxt;
    logic [CW-1:0] w_free_nxt;

    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == CW'(DEPTH));
    assign w_rd        = !w_empty && out_ready;
    // A read in the same cycle frees the slot, so a full FIFO can still accept.
    assign w_wr        = in_data_vld && (!w_full || w_rd);
    assign w_ovf       = in_data_vld && w_full && !w_rd;
    assign w_count_nxt = r_count + CW'(w_wr) - CW'(w_rd);
    assign w_free_nxt  = CW'(DEPTH) - w_count_nxt;

    assign w_sop     = (r_state == S_IDLE);
    assign w_eop     = (r_state == S_PARITY);
    assign w_hdr_bad = in_data_vld && w_sop && (in_data[1:0] == 2'b11);
    assign w_par_bad = in_data_vld && w_eop && (in_data != r_acc);
    assign w_err_now = w_hdr_bad || w_par_bad || w_ovf;

    assign out_vld    = !w_empty;
    assign out_data   = w_empty ? 8'h00 : r_mem[r_rd_ptr][7:0];
    assign out_sop    = !w_empty && r_mem[r_rd_ptr][9];
    assign out_eop    = !w_empty && r_mem[r_rd_ptr][8];
    assign in_suspend = r_suspend;
    assign error      = r_error;
    assign dbg_state  = r_state;

    always_ff @(posedge clock) begin
        if (w_wr) r_mem[r_wr_ptr] <= {w_sop, w_eop, in_data};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_suspend <= 1'b1;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count   <= w_count_nxt;
            r_suspend <= (w_free_nxt <= CW'(SUSP_THRESH));
        end
    end

    // The parser advances on every valid byte, even a dropped one, to keep framing.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_len   <= '0;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_error <= 1'b0;
        end else begin
            r_error <= w_err_now;
            if (in_data_vld) begin
                case (r_state)
                    S_IDLE: begin
                        r_len   <= in_data[7:2];
                        r_acc   <= in_data;
                        r_cnt   <= '0;
                        r_state <= (in_data[7:2] != 6'd0) ? S_PAYLOAD : S_PARITY;
                    end
                    S_PAYLOAD: begin
                        r_acc <= r_acc ^ in_data;
                        r_cnt <= r_cnt + 6'd1;
                        if (r_cnt + 6'd1 == r_len) r_state <= S_PARITY;
                    end
                    S_PARITY: r_state <= S_IDLE;
                    default:  r_state <= S_IDLE;
                endcase
            end
        end
    end

`ifdef YAPP_RX_STATS_EN
    logic r_pkt_bad;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pkt_bad    <= 1'b0;
            good_pkt_cnt <= '0;
            bad_pkt_cnt  <= '0;
        end else if (in_data_vld) begin
            if (w_sop) begin
                r_pkt_bad <= w_err_now;
            end else if (w_eop) begin
                r_pkt_bad <= 1'b0;
                if (r_pkt_bad || w_err_now) begin
                    if (bad_pkt_cnt != 16'hFFFF) bad_pkt_cnt <= bad_pkt_cnt + 16'd1;
                end else begin
                    if (good_pkt_cnt != 16'hFFFF) good_pkt_cnt <= good_pkt_cnt + 16'd1;
                end
            end else begin
                r_pkt_bad <= r_pkt_bad || w_err_now;
            end
        end
    end
`endif

endmodule
